// File: rtl/ram_fifo_pkg.sv
// rtl/ram_fifo_pkg.sv - shared constants and types for the RAM-backed FIFO controller
//
// Purpose: default widths for ram_fifo_ctrl, the skid occupancy type and the
//          number of skid entries that absorb the RAM's 1-cycle read latency.
// Ports:   none (package).
package ram_fifo_pkg;

  localparam int RF_ADDR_WIDTH = 4;
  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_DEPTH      = 16;

  // Two entries: one for the word arriving from the RAM and one for the word
  // the consumer has not yet taken, so a fetch can be issued every cycle.
  localparam int SKID_ENTRIES  = 2;

  // Total occupancy at default width: RAM (0..DEPTH) + in-flight + skid.
  typedef logic [RF_ADDR_WIDTH+1:0] count_t;

  // Skid occupancy, 0..SKID_ENTRIES.
  typedef logic [1:0] skid_cnt_t;

endpackage

// File: rtl/ram_fifo_skid.sv
// rtl/ram_fifo_skid.sv - 2-entry register FIFO forming the FIFO output stage
//
// Purpose: holds words returned by the RAM until the consumer takes them.
//          Entry 0 is always the head; enqueue and dequeue may coincide when
//          the stage holds one or two words.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   enq, enq_data     write a word (caller guarantees no overflow)
//   deq               remove the head word (caller guarantees not empty)
//   cnt               current occupancy 0..2
//   head              head word (0 after reset)
module ram_fifo_skid
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output skid_cnt_t             cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  skid_cnt_t             cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({enq, deq})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = enq_data;
        else               ent1_d = enq_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          ent0_d = enq_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = enq_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign head = ent0_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller driving a simple dual-port RAM with registered read
//
// Purpose: turns a valid/ready push stream and a valid/ready pop stream into
//          RAM write/read strobes, hiding the 1-cycle read latency behind a
//          2-entry skid so a ready consumer receives one word per cycle.
// Optional: RAM_FIFO_CTRL_ALMOST_EN adds almost_full / almost_empty outputs.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   s_valid, s_ready, s_data       push stream
//   m_valid, m_ready, m_data       pop stream
//   count                          words held (RAM + in flight + skid)
//   ram_we, ram_wr_addr, ram_wr_din  RAM write port
//   ram_re, ram_rd_addr, ram_rd_dout RAM read port (dout valid cycle after re)
//   almost_full, almost_empty      threshold flags (optional)
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_din,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_dout
`ifdef RAM_FIFO_CTRL_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int MW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
  logic                  pend_q, pend_d;
  skid_cnt_t             skid_cnt;
  logic                  push;
  logic                  pop;
  logic [2:0]            skid_occ;

  // Full is judged on registered mem_cnt only, so a slot freed by this
  // cycle's fetch cannot be reused until the next cycle.
  assign s_ready = (mem_cnt_q != MW'(DEPTH));
  assign push    = s_valid & s_ready;
  assign m_valid = (skid_cnt != 2'd0);
  assign pop     = m_valid & m_ready;

  // Skid occupancy one cycle ahead if no fetch is issued now; fetching is
  // allowed only while that leaves room for the word this fetch returns.
  assign skid_occ = {1'b0, skid_cnt} + {2'b00, pend_q} - {2'b00, pop};
  assign ram_re   = (mem_cnt_q != '0) && (skid_occ < 3'(SKID_ENTRIES));

  assign ram_we      = push;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_din  = s_data;
  assign ram_rd_addr = rd_ptr_q;

  // mem_cnt covers committed writes only, so the read address never equals
  // the address being written this cycle and no bypass is needed.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(ram_re);
    mem_cnt_d = mem_cnt_q + MW'(push) - MW'(ram_re);
    pend_d    = ram_re;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // pend_q marks that ram_rd_dout carries a fetched word this cycle; after a
  // reset it is 0, so a read launched before reset is dropped.
  ram_fifo_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .enq      (pend_q),
    .enq_data (ram_rd_dout),
    .deq      (pop),
    .cnt      (skid_cnt),
    .head     (m_data)
  );

  assign count = CW'(mem_cnt_q) + CW'(pend_q) + CW'(skid_cnt);

`ifdef RAM_FIFO_CTRL_ALMOST_EN
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
`else
  logic unused_thresh;
  assign unused_thresh = ^{AF_THRESH[0], AE_THRESH[0]};
`endif

endmodule
